// File: rtl/seq_detect_scheduler_pkg.sv
// Shared defaults and types for the serial pattern-match scheduler.
package seq_sched_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int PAT_W_DEF  = 6;
    localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 6'b110011;

    typedef logic [$clog2(NUM_CH_DEF)-1:0] ch_idx_t;
    typedef logic [PAT_W_DEF-1:0]          hist_t;

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Bundle of the per-channel bit streams and the detection outputs.
interface seq_detect_scheduler_if
    import seq_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
);
    localparam int IW = $clog2(NUM_CH);

    logic              flush;
    logic [NUM_CH-1:0] in_valid;
    logic [NUM_CH-1:0] in_bit;
    logic [NUM_CH-1:0] in_ready;
    logic              det_valid;
    logic [IW-1:0]     det_ch;
    logic [7:0]        det_count;

    modport master (
        output flush, in_valid, in_bit,
        input  in_ready, det_valid, det_ch, det_count
    );

    modport slave (
        input  flush, in_valid, in_bit,
        output in_ready, det_valid, det_ch, det_count
    );

endinterface

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // Scanning from the farthest offset down lets the closest requester win last.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shares one pattern comparator across NUM_CH serial streams, one accepted bit per cycle.
module seq_detect_scheduler
    import seq_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int PAT_W  = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEF)
) (
    input  logic clk,
    input  logic rst,
    seq_detect_scheduler_if.slave bus
);

    localparam int IW = $clog2(NUM_CH);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] hist [NUM_CH];
    logic [FW-1:0]    fill [NUM_CH];
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    ptr_next;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic             transfer;
    logic [PAT_W-1:0] next_hist;
    logic [FW-1:0]    next_fill;
    logic             match;

    logic             det_valid_q;
    logic [IW-1:0]    det_ch_q;
    logic [7:0]       det_count_q;

    assign req = bus.flush ? '0 : bus.in_valid;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign bus.in_ready = gnt;
    assign transfer     = |gnt;

    // The fill count keeps an all-zero reset history from matching an all-zero pattern.
    assign next_hist = {hist[gnt_idx][PAT_W-2:0], bus.in_bit[gnt_idx]};
    assign next_fill = (fill[gnt_idx] == FULL) ? FULL : fill[gnt_idx] + FW'(1);
    assign match     = transfer && (next_hist == PATTERN) && (next_fill == FULL);
    assign ptr_next  = (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + IW'(1);

    // Flush clears progress but leaves the fairness pointer and last det_ch alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hist[i] <= '0;
                fill[i] <= '0;
            end
            ptr         <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            det_count_q <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hist[i] <= '0;
                fill[i] <= '0;
            end
            det_valid_q <= 1'b0;
            det_count_q <= '0;
        end else begin
            if (transfer) begin
                hist[gnt_idx] <= next_hist;
                fill[gnt_idx] <= next_fill;
                ptr           <= ptr_next;
            end
            det_valid_q <= match;
            if (match) begin
                det_ch_q    <= gnt_idx;
                det_count_q <= det_count_q + 8'd1;
            end
        end
    end

    assign bus.det_valid = det_valid_q;
    assign bus.det_ch    = det_ch_q;
    assign bus.det_count = det_count_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler with a per-cycle reference model of streams and arbitration.
module tb_seq_detect_scheduler;

    localparam int NUM_CH = 4;
    localparam int PAT_W  = 6;
    localparam logic [PAT_W-1:0] PAT = 6'b110011;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seq_detect_scheduler_if #(.NUM_CH(NUM_CH)) bus  ();
    seq_detect_scheduler_if #(.NUM_CH(NUM_CH)) zbus ();

    seq_detect_scheduler #(.NUM_CH(NUM_CH), .PAT_W(PAT_W), .PATTERN(PAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seq_detect_scheduler #(.NUM_CH(NUM_CH), .PAT_W(PAT_W), .PATTERN(6'b000000)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (zbus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: each stream is a running value of its last PAT_W bits plus a count of bits seen.
    int m_ptr = 0;
    int m_val [NUM_CH];
    int m_bits [NUM_CH];
    int m_count = 0;
    bit m_dv = 1'b0;
    int m_dch = 0;

    function automatic int pick(input logic [NUM_CH-1:0] v, input int p, input logic fl);
        if (fl) return -1;
        for (int k = 0; k < NUM_CH; k++) begin
            int j = (p + k) % NUM_CH;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_val[c]  <= 0;
                m_bits[c] <= 0;
            end
            m_ptr   <= 0;
            m_count <= 0;
            m_dv    <= 1'b0;
            m_dch   <= 0;
        end else if (bus.flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_val[c]  <= 0;
                m_bits[c] <= 0;
            end
            m_count <= 0;
            m_dv    <= 1'b0;
        end else begin
            int g, nv, nb;
            g = pick(bus.in_valid, m_ptr, 1'b0);
            m_dv <= 1'b0;
            if (g >= 0) begin
                nv = (m_val[g] * 2 + int'(bus.in_bit[g])) % (1 << PAT_W);
                nb = m_bits[g] + 1;
                m_val[g]  <= nv;
                m_bits[g] <= nb;
                m_ptr     <= (g + 1) % NUM_CH;
                if (nb >= PAT_W && nv == int'(PAT)) begin
                    m_dv    <= 1'b1;
                    m_dch   <= g;
                    m_count <= (m_count + 1) % 256;
                end
            end
        end
    end

    bit cmp_en = 1'b0;
    int pulses = 0;
    int pulse_ch [8];

    always @(negedge clk) begin
        if (cmp_en) begin
            int g;
            g = pick(bus.in_valid, m_ptr, bus.flush);
            checkOutput("in_ready", int'(bus.in_ready), (g < 0) ? 0 : (1 << g));
            checkOutput("det_valid", int'(bus.det_valid), int'(m_dv));
            checkOutput("det_count", int'(bus.det_count), m_count);
            if (m_dv) checkOutput("det_ch", int'(bus.det_ch), m_dch);
            if (bus.det_valid) begin
                if (pulses < 8) pulse_ch[pulses] = int'(bus.det_ch);
                pulses++;
            end
        end
    end

    logic [NUM_CH-1:0] gnt_seen;
    logic [PAT_W-1:0]  pat_v;
    int               s_mode [NUM_CH];
    logic [31:0]      s_seq  [NUM_CH];
    int               s_len  [NUM_CH];
    int               s_idx  [NUM_CH];
    int               s_cycles;

    task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] b, input logic fl);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.flush    = fl;
        #1;
        gnt_seen = bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    function automatic logic streamBit(input int c, input int k);
        if (s_mode[c] == 0) return s_seq[c][s_len[c] - 1 - k];
        if (k < PAT_W) return pat_v[PAT_W - 1 - k];
        return ((k - PAT_W) % 4) >= 2;
    endfunction

    task automatic clearStreams();
        for (int c = 0; c < NUM_CH; c++) begin
            s_mode[c] = 0;
            s_seq[c]  = '0;
            s_len[c]  = 0;
        end
    endtask

    // Presents each stream's next bit while it has bits left; advances only on a grant.
    task automatic runStreams(input int max_cycles);
        logic [NUM_CH-1:0] v, b;
        bit busy;
        s_cycles = 0;
        for (int c = 0; c < NUM_CH; c++) s_idx[c] = 0;
        busy = 1'b1;
        while (busy && s_cycles < max_cycles) begin
            for (int c = 0; c < NUM_CH; c++) begin
                v[c] = s_idx[c] < s_len[c];
                b[c] = v[c] ? streamBit(c, s_idx[c]) : 1'b0;
            end
            applyStimulus(v, b, 1'b0);
            for (int c = 0; c < NUM_CH; c++) if (gnt_seen[c]) s_idx[c]++;
            busy = 1'b0;
            for (int c = 0; c < NUM_CH; c++) if (s_idx[c] < s_len[c]) busy = 1'b1;
            s_cycles++;
        end
        bus.in_valid = '0;
        bus.in_bit   = '0;
        checkOutput("stream_timeout", int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int zp;
        int gcount [NUM_CH];
        pat_v          = PAT;
        bus.in_valid   = '0;
        bus.in_bit     = '0;
        bus.flush      = 1'b0;
        zbus.in_valid  = '0;
        zbus.in_bit    = '0;
        zbus.flush     = 1'b0;
        clearStreams();

        #12 rst = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        checkOutput("reset_det_valid", int'(bus.det_valid), 0);
        checkOutput("reset_det_count", int'(bus.det_count), 0);
        bus.in_valid = 4'b1010;
        #1;
        checkOutput("reset_ptr_grant", int'(bus.in_ready), 4'b0010);
        bus.in_valid = '0;

        $display("[TB] single channel");
        clearStreams();
        s_seq[0] = 32'b110011; s_len[0] = 6;
        pulses = 0;
        runStreams(20);
        checkOutput("single_cycles", s_cycles, 6);
        checkOutput("single_det_valid", int'(bus.det_valid), 1);
        checkOutput("single_det_ch", int'(bus.det_ch), 0);
        checkOutput("single_det_count", int'(bus.det_count), 1);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("flush_clears_count", int'(bus.det_count), 0);

        $display("[TB] interleave");
        clearStreams();
        s_seq[0] = 32'b110011; s_len[0] = 6;
        s_seq[1] = 32'b110011; s_len[1] = 6;
        pulses = 0;
        runStreams(30);
        applyStimulus('0, '0, 1'b0);
        checkOutput("inter_cycles", s_cycles, 12);
        checkOutput("inter_pulses", pulses, 2);
        checkOutput("inter_first_ch", pulse_ch[0], 0);
        checkOutput("inter_second_ch", pulse_ch[1], 1);
        checkOutput("inter_det_count", int'(bus.det_count), 2);
        applyStimulus('0, '0, 1'b1);

        $display("[TB] overlap");
        clearStreams();
        s_seq[2] = 32'b1100110011; s_len[2] = 10;
        pulses = 0;
        runStreams(30);
        applyStimulus('0, '0, 1'b0);
        checkOutput("overlap_pulses", pulses, 2);
        checkOutput("overlap_ch0", pulse_ch[0], 2);
        checkOutput("overlap_ch1", pulse_ch[1], 2);
        checkOutput("overlap_det_count", int'(bus.det_count), 2);
        applyStimulus('0, '0, 1'b1);

        $display("[TB] fill gate");
        zp = 0;
        for (int i = 0; i < 5; i++) begin
            zbus.in_valid = 4'b0001;
            zbus.in_bit   = 4'b0000;
            @(posedge clk);
            #1;
            if (zbus.det_valid) zp++;
        end
        checkOutput("fill_gate_5_pulses", zp, 0);
        checkOutput("fill_gate_5_count", int'(zbus.det_count), 0);
        @(posedge clk);
        #1;
        zbus.in_valid = '0;
        checkOutput("fill_gate_6_valid", int'(zbus.det_valid), 1);
        checkOutput("fill_gate_6_count", int'(zbus.det_count), 1);

        $display("[TB] flush mid-pattern");
        clearStreams();
        s_seq[3] = 32'b11001; s_len[3] = 5;
        pulses = 0;
        runStreams(20);
        applyStimulus(4'b1000, 4'b1000, 1'b1);
        checkOutput("flush_in_ready", int'(gnt_seen), 0);
        clearStreams();
        s_seq[3] = 32'b1; s_len[3] = 1;
        runStreams(5);
        applyStimulus('0, '0, 1'b0);
        checkOutput("flush_pulses", pulses, 0);
        checkOutput("flush_det_count", int'(bus.det_count), 0);

        $display("[TB] reset mid-pattern");
        clearStreams();
        s_seq[1] = 32'b11001; s_len[1] = 5;
        pulses = 0;
        runStreams(20);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_det_count", int'(bus.det_count), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        clearStreams();
        s_seq[1] = 32'b1; s_len[1] = 1;
        runStreams(5);
        applyStimulus('0, '0, 1'b0);
        checkOutput("rst_mid_pulses", pulses, 0);

        $display("[TB] wrap");
        applyStimulus('0, '0, 1'b1);
        clearStreams();
        for (int c = 0; c < NUM_CH; c++) begin
            s_mode[c] = 1;
            s_len[c]  = PAT_W + 63 * 4;
        end
        pulses = 0;
        runStreams(2000);
        checkOutput("wrap_pulses_before_last", pulses, 255);
        checkOutput("wrap_last_valid", int'(bus.det_valid), 1);
        checkOutput("wrap_det_count", int'(bus.det_count), 0);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_drop", int'(bus.det_valid), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] fairness");
        for (int c = 0; c < NUM_CH; c++) gcount[c] = 0;
        for (int i = 0; i < 4 * NUM_CH; i++) begin
            applyStimulus('1, '0, 1'b0);
            for (int c = 0; c < NUM_CH; c++) if (gnt_seen[c]) gcount[c]++;
        end
        applyStimulus('0, '0, 1'b0);
        for (int c = 0; c < NUM_CH; c++) checkOutput($sformatf("fair_ch%0d", c), gcount[c], 4);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
